// File: rtl/vga_pixel_fetch_if.sv
`default_nettype none
// ============================================================================
// vga_pixel_fetch_if : timing-generator, frame-RAM and pixel-output bundle
// Revision 1.0
// ============================================================================
interface vga_pixel_fetch_if #(
    parameter int AW = 15
);
    logic [9:0]    hCount;
    logic [8:0]    vCount;
    logic          hSyncIn;
    logic          vSyncIn;
    logic          activeIn;
    logic          showEdges;
    logic [7:0]    threshold;
    logic          frameReady;
    logic [AW-1:0] rdAddr;
    logic          rdBank;
    logic [7:0]    rdData;
    logic          writeBank;
    logic          swapAck;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic          hSyncOut;
    logic          vSyncOut;
    logic          activeOut;

    modport master (
        output hCount, vCount, hSyncIn, vSyncIn, activeIn,
        output showEdges, threshold, frameReady, rdData,
        input  rdAddr, rdBank, writeBank, swapAck,
        input  r, g, b, hSyncOut, vSyncOut, activeOut
    );

    modport slave (
        input  hCount, vCount, hSyncIn, vSyncIn, activeIn,
        input  showEdges, threshold, frameReady, rdData,
        output rdAddr, rdBank, writeBank, swapAck,
        output r, g, b, hSyncOut, vSyncOut, activeOut
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// vga_pixel_fetch : frame-buffer address generation, SCALEx upscale, edge
//                   overlay and display/write bank swap at vertical blank
// Revision 1.0
// ============================================================================
module vga_pixel_fetch #(
    parameter int          HACTIVE  = 640,
    parameter int          VACTIVE  = 480,
    parameter int          SCALE    = 4,
    parameter int          IMG_W    = 160,
    parameter int          IMG_H    = 120,
    parameter int          AW       = 15,
    parameter logic [23:0] EDGE_RGB = 24'h00FF00
) (
    input  wire logic        vgaClk,
    input  wire logic        rst,
    vga_pixel_fetch_if.slave bus
);
    localparam int         SHIFT   = $clog2(SCALE);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    generate
        if ((IMG_W * SCALE != HACTIVE) || (IMG_H * SCALE != VACTIVE) ||
            ((2 ** AW) < (IMG_W * IMG_H))) begin : g_param_check
            $error("vga_pixel_fetch: inconsistent image geometry parameters");
        end
    endgenerate

    logic [AW-1:0] line_base;
    logic [AW-1:0] rd_addr;
    logic          line_end;
    logic          frame_end;

    // Last pixel of the final display line that maps onto one stored image row.
    assign line_end  = bus.activeIn && (bus.hCount == 10'(HACTIVE - 1)) &&
                       ((bus.vCount & 9'(SCALE - 1)) == 9'(SCALE - 1));
    assign frame_end = (bus.vCount == 9'(VACTIVE)) && (bus.hCount == 10'd0);

    always_ff @(posedge vgaClk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            rd_addr   <= '0;
        end else begin
            if (frame_end)
                line_base <= '0;
            else if (line_end)
                line_base <= line_base + AW'(IMG_W);
            if (bus.activeIn)
                rd_addr <= line_base + AW'(bus.hCount >> SHIFT);
        end
    end

    logic [2:0] act_pipe;
    logic [2:0] hs_pipe;
    logic [2:0] vs_pipe;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;

    // act_pipe[1] lines up with rdData, bit 2 with the registered colour.
    always_ff @(posedge vgaClk or posedge rst) begin
        if (rst) begin
            act_pipe <= 3'b000;
            hs_pipe  <= 3'b111;
            vs_pipe  <= 3'b111;
            pix_r    <= 8'h00;
            pix_g    <= 8'h00;
            pix_b    <= 8'h00;
        end else begin
            act_pipe <= {act_pipe[1:0], bus.activeIn};
            hs_pipe  <= {hs_pipe[1:0], bus.hSyncIn};
            vs_pipe  <= {vs_pipe[1:0], bus.vSyncIn};
            if (!act_pipe[1]) begin
                {pix_r, pix_g, pix_b} <= 24'h000000;
            end else if (bus.showEdges && (bus.rdData >= bus.threshold)) begin
                {pix_r, pix_g, pix_b} <= EDGE_RGB;
            end else begin
                {pix_r, pix_g, pix_b} <= {bus.rdData, bus.rdData, bus.rdData};
            end
        end
    end

    logic [0:0] state;
    logic [0:0] state_next;
    logic       swap_fire;
    logic       disp_bank;
    logic       swap_ack;

    always_ff @(posedge vgaClk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Extra frameReady pulses while PENDING collapse into the one swap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.frameReady && !frame_end)
                    state_next = PENDING;
            end
            PENDING: begin
                if (frame_end)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        swap_fire = 1'b0;
        if (frame_end && ((state == PENDING) || bus.frameReady))
            swap_fire = 1'b1;
    end

    always_ff @(posedge vgaClk or posedge rst) begin
        if (rst) begin
            disp_bank <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= swap_fire;
            if (swap_fire)
                disp_bank <= ~disp_bank;
        end
    end

    assign bus.rdAddr    = rd_addr;
    assign bus.rdBank    = disp_bank;
    assign bus.writeBank = ~disp_bank;
    assign bus.swapAck   = swap_ack;
    assign bus.r         = pix_r;
    assign bus.g         = pix_g;
    assign bus.b         = pix_b;
    assign bus.hSyncOut  = hs_pipe[2];
    assign bus.vSyncOut  = vs_pipe[2];
    assign bus.activeOut = act_pipe[2];
endmodule
`default_nettype wire
